// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: owner/access-size encodings and the read-latency range check shared by the arbiter.
package mem_port_arbiter_pkg;

    localparam logic OWNER_IF = 1'b0;
    localparam logic OWNER_D  = 1'b1;

    typedef enum logic [1:0] {
        OP_BYTE = 2'b00,
        OP_HALF = 2'b01,
        OP_WORD = 2'b10
    } mem_op_e;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 4;

    function automatic logic rd_lat_ok(input int lat);
        return lat >= RD_LAT_MIN && lat <= RD_LAT_MAX;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_tag_pipe.sv
// mem_tag_pipe: latency-matched {valid, owner} shift pipeline; kill_if drops every IF tag,
// including one leaving the last stage in the same cycle.
module mem_tag_pipe
    import mem_port_arbiter_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid,
    input  logic in_owner,
    input  logic kill_if,
    output logic out_valid,
    output logic out_owner,
    output logic busy
);

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [DEPTH-1:0] owner_q, owner_d;
    logic [DEPTH-1:0] live;

    always_comb begin
        for (int i = 0; i < DEPTH; i++)
            live[i] = valid_q[i] & ~(kill_if & (owner_q[i] == OWNER_IF));
        valid_d[0] = in_valid;
        owner_d[0] = in_owner;
        for (int i = 1; i < DEPTH; i++) begin
            valid_d[i] = live[i-1];
            owner_d[i] = owner_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            owner_q <= '0;
        end else begin
            valid_q <= valid_d;
            owner_q <= owner_d;
        end
    end

    assign out_valid = live[DEPTH-1];
    assign out_owner = owner_q[DEPTH-1];
    assign busy      = |valid_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency single-port memory between IF and data requesters.
// Define MEM_ARB_RR_EN to alternate grants on ties instead of fixed data-over-IF priority.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int RD_LATENCY = 1,
    parameter int ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [1:0]        d_op,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    input  logic              flush,
    output logic              mem_en,
    output logic              mem_we,
    output logic [1:0]        mem_op,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              busy
);

    if (!rd_lat_ok(RD_LATENCY)) begin : g_bad_latency
        $error("mem_port_arbiter: RD_LATENCY must be within 1..4");
    end

`ifdef MEM_ARB_RR_EN
    logic last_q, last_d;
    logic tie;

    // A flush-blocked IF is not a contender, so it never moves the pointer.
    always_comb begin
        tie    = d_req & if_req & ~flush;
        d_gnt  = d_req & (~tie | (last_q == OWNER_IF));
        if_gnt = if_req & ~flush & (~d_req | (tie & (last_q == OWNER_D)));
        last_d = d_gnt ? OWNER_D : if_gnt ? OWNER_IF : last_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_q <= OWNER_IF;
        else        last_q <= last_d;
    end
`else
    assign d_gnt  = d_req;
    assign if_gnt = if_req & ~flush & ~d_req;
`endif

    assign mem_en    = d_gnt | if_gnt;
    assign mem_we    = d_gnt & d_we;
    assign mem_op    = d_gnt ? d_op : OP_WORD;
    assign mem_addr  = d_gnt ? d_addr : if_addr;
    assign mem_wdata = d_gnt ? d_wdata : '0;

    logic tag_valid, tag_owner;

    mem_tag_pipe #(.DEPTH(RD_LATENCY)) u_tags (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (mem_en & ~mem_we),
        .in_owner (d_gnt ? OWNER_D : OWNER_IF),
        .kill_if  (flush),
        .out_valid(tag_valid),
        .out_owner(tag_owner),
        .busy     (busy)
    );

    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;

    always_comb begin
        if_rvalid  = tag_valid & (tag_owner == OWNER_IF);
        d_rvalid   = tag_valid & (tag_owner == OWNER_D);
        if_rdata_d = if_rvalid ? mem_rdata : if_rdata_q;
        d_rdata_d  = d_rvalid ? mem_rdata : d_rdata_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    assign if_rdata = if_rdata_d;
    assign d_rdata  = d_rdata_d;

endmodule
